apb_reg_slave: RTL and testbench

- APB2 responder (no PREADY/PSLVERR) at the peripheral end of the AHB-to-APB bridge. One instance hangs off one bit of the bridge's Pselx.
- Implements a small register bank: control, sticky status, a 32-bit event counter and five scratch registers.
- Checks the APB phase sequence and flags violations. Raises a maskable interrupt.

---
 rtl/apb_reg_slave.sv | 186 ++++++++++++++++++
 tb/tb_apb_reg_slave.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// APB2 responder with control/status/counter/scratch registers, phase-sequence
// checking and a maskable, registered interrupt.
module apb_reg_slave #(
    parameter logic [31:0] CNT_RESET = 32'h0000_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        irq
);

    // Phase observed in the previous cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  lat_addr;
    logic        lat_write;

    logic [3:0]  ctrl;
    logic [1:0]  status;
    logic [31:0] count;
    logic [31:0] scratch [0:4];

    logic [2:0]  addr;
    logic        setup_phase;
    logic        access_phase;
    logic        latch;
    logic        commit;
    logic        perr;
    logic        wr_en;
    logic        rd_load;
    logic        ctrl_we;
    logic        status_we;
    logic        cnt_clear;
    logic        cnt_wrap;
    logic [1:0]  w1c;
    logic [31:0] rdata;

    assign addr         = Paddr[4:2];
    assign setup_phase  = Psel & ~Penable;
    assign access_phase = Psel & Penable;

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        commit     = 1'b0;
        perr       = 1'b0;
        case (state)
            IDLE: begin
                if (setup_phase) begin
                    state_next = SETUP;
                    latch      = 1'b1;
                end else if (access_phase) begin
                    perr = 1'b1;
                end
            end
            SETUP: begin
                if (access_phase && (addr == lat_addr) && (Pwrite == lat_write)) begin
                    state_next = ACCESS;
                    commit     = 1'b1;
                end else begin
                    state_next = IDLE;
                    perr       = 1'b1;
                end
            end
            ACCESS: begin
                if (setup_phase) begin
                    state_next = SETUP;
                    latch      = 1'b1;
                end else if (!Psel) begin
                    state_next = IDLE;
                end else begin
                    state_next = IDLE;
                    perr       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_en     = commit & lat_write;
    assign rd_load   = latch & ~Pwrite;
    assign ctrl_we   = wr_en && (lat_addr == 3'd0);
    assign status_we = wr_en && (lat_addr == 3'd1);
    // Clear acts on the commit edge itself and overrides any increment there.
    assign cnt_clear = ctrl_we & Pwdata[1];
    assign cnt_wrap  = ctrl[0] & ~cnt_clear & (count == 32'hFFFF_FFFF);
    assign w1c       = status_we ? Pwdata[1:0] : 2'b00;

    always_comb begin
        rdata = 32'h0;
        case (addr)
            3'd0: rdata = {28'h0, ctrl};
            3'd1: rdata = {30'h0, status};
            3'd2: rdata = count;
            3'd3: rdata = scratch[0];
            3'd4: rdata = scratch[1];
            3'd5: rdata = scratch[2];
            3'd6: rdata = scratch[3];
            3'd7: rdata = scratch[4];
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= IDLE;
            lat_addr  <= 3'd0;
            lat_write <= 1'b0;
        end else begin
            state <= state_next;
            if (latch) begin
                lat_addr  <= addr;
                lat_write <= Pwrite;
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            ctrl <= 4'h0;
        end else if (ctrl_we) begin
            ctrl <= Pwdata[3:0];
        end else begin
            ctrl[1] <= 1'b0;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            count <= CNT_RESET;
        end else if (cnt_clear) begin
            count <= CNT_RESET;
        end else if (ctrl[0]) begin
            count <= count + 32'd1;
        end
    end

    // Hardware set beats a simultaneous write-one-to-clear.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            status <= 2'b00;
        end else begin
            status <= (status & ~w1c) | {cnt_wrap, perr};
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < 5; i++) begin
                scratch[i] <= 32'h0;
            end
        end else if (wr_en) begin
            case (lat_addr)
                3'd3: scratch[0] <= Pwdata;
                3'd4: scratch[1] <= Pwdata;
                3'd5: scratch[2] <= Pwdata;
                3'd6: scratch[3] <= Pwdata;
                3'd7: scratch[4] <= Pwdata;
                default: ;
            endcase
        end
    end

    // Read data lives only for the access cycle; zero otherwise.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Prdata <= 32'h0;
            irq    <= 1'b0;
        end else begin
            Prdata <= rd_load ? rdata : 32'h0;
            irq    <= |(status & ctrl[3:2]);
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: two instances share the bus, the second
// starts its counter just below wrap.
module tb_apb_reg_slave;

    logic        Hclk;
    logic        Hresetn;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        irq;
    logic [31:0] prdata_ovf;
    logic        irq_ovf;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    apb_reg_slave u_dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .Psel    (Psel),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Paddr   (Paddr),
        .Pwdata  (Pwdata),
        .Prdata  (Prdata),
        .irq     (irq)
    );

    apb_reg_slave #(.CNT_RESET(32'hFFFF_FFFE)) u_dut_ovf (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .Psel    (Psel),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Paddr   (Paddr),
        .Pwdata  (Pwdata),
        .Prdata  (prdata_ovf),
        .irq     (irq_ovf)
    );

    // clock
    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_idle(input int n);
        Psel    = 1'b0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        repeat (n) begin
            @(posedge Hclk);
            #1;
        end
    endtask

    // Leaves the bus in the access phase; follow with bus_idle or another transfer.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        Psel    = 1'b1;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = addr;
        Pwdata  = data;
        @(posedge Hclk);
        #1;
        Penable = 1'b1;
        @(posedge Hclk);
        #1;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] d, output logic [31:0] d_ovf);
        Psel    = 1'b1;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = addr;
        Pwdata  = 32'h0;
        @(posedge Hclk);
        #1;
        Penable = 1'b1;
        d       = Prdata;
        d_ovf   = prdata_ovf;
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] dv;

        Hresetn = 1'b0;
        Psel    = 1'b0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = 32'h0;
        Pwdata  = 32'h0;
        repeat (3) begin
            @(posedge Hclk);
            #1;
        end
        Hresetn = 1'b1;
        bus_idle(1);
        check("rst_prdata", Prdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        // reset values of every address, back to back
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back((i == 2) ? 32'hFFFF_FFFE : 32'h0);
            apb_read(i * 4, d, dv);
            check($sformatf("rst_rd_%0d", i), d, 32'h0);
            check($sformatf("rst_rd_ovf_%0d", i), dv, exp_q.pop_front());
        end
        bus_idle(1);

        // scratch write/read, then back-to-back write-read
        apb_write(32'h0C, 32'hDEAD_BEEF);
        bus_idle(1);
        apb_read(32'h0C, d, dv);
        check("scr0_rd", d, 32'hDEAD_BEEF);
        check("scr0_after", Prdata, 32'h0);
        apb_write(32'h10, 32'h1234_5678);
        apb_read(32'h10, d, dv);
        check("scr1_b2b", d, 32'h1234_5678);
        apb_read(32'hFFFF_FFF0, d, dv);
        check("scr1_alias", d, 32'h1234_5678);

        // COUNT is read-only
        apb_write(32'h08, 32'h0000_FFFF);
        apb_read(32'h08, d, dv);
        check("cnt_ro", d, 32'h0);
        bus_idle(1);

        // enable, 10 idle cycles, disable: 10 + 2 write cycles
        apb_write(32'h00, 32'h1);
        bus_idle(10);
        apb_write(32'h00, 32'h0);
        apb_read(32'h08, d, dv);
        check("cnt_run", d, 32'd12);

        // clear+enable, self-clearing bit1, clear beats increment
        apb_write(32'h00, 32'h3);
        apb_read(32'h08, d, dv);
        check("cnt_clr", d, 32'h0);
        apb_read(32'h00, d, dv);
        check("ctrl_selfclr", d, 32'h1);
        apb_write(32'h00, 32'h3);
        apb_write(32'h00, 32'h0);
        apb_read(32'h08, d, dv);
        check("cnt_clr_wins", d, 32'd2);
        bus_idle(1);

        // protocol error: access phase straight from idle
        Psel    = 1'b1;
        Penable = 1'b1;
        Pwrite  = 1'b1;
        Paddr   = 32'h0C;
        Pwdata  = 32'h1111_1111;
        @(posedge Hclk);
        #1;
        bus_idle(1);
        apb_read(32'h0C, d, dv);
        check("perr1_nowr", d, 32'hDEAD_BEEF);
        apb_read(32'h04, d, dv);
        check("perr1_stat", d, 32'h1);
        check("perr1_irq_masked", {31'h0, irq}, 32'h0);
        apb_write(32'h04, 32'h1);
        apb_read(32'h04, d, dv);
        check("perr1_w1c", d, 32'h0);
        bus_idle(1);

        // protocol error: address changes between setup and access
        Psel    = 1'b1;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = 32'h0C;
        Pwdata  = 32'h2222_2222;
        @(posedge Hclk);
        #1;
        Penable = 1'b1;
        Paddr   = 32'h10;
        @(posedge Hclk);
        #1;
        bus_idle(1);
        apb_read(32'h0C, d, dv);
        check("perr2_scr0", d, 32'hDEAD_BEEF);
        apb_read(32'h10, d, dv);
        check("perr2_scr1", d, 32'h1234_5678);
        apb_read(32'h04, d, dv);
        check("perr2_stat", d, 32'h1);
        apb_write(32'h00, 32'h4);
        check("perr2_irq_lag", {31'h0, irq}, 32'h0);
        bus_idle(1);
        check("perr2_irq", {31'h0, irq}, 32'h1);

        // async reset in the access cycle of a write
        Psel    = 1'b1;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = 32'h14;
        Pwdata  = 32'hAAAA_AAAA;
        @(posedge Hclk);
        #1;
        Penable = 1'b1;
        #2;
        Hresetn = 1'b0;
        #1;
        check("arst_irq", {31'h0, irq}, 32'h0);
        Psel    = 1'b0;
        Penable = 1'b0;
        repeat (2) begin
            @(posedge Hclk);
            #1;
        end
        Hresetn = 1'b1;
        bus_idle(1);
        apb_read(32'h14, d, dv);
        check("arst_scr2", d, 32'h0);
        apb_read(32'h0C, d, dv);
        check("arst_scr0", d, 32'h0);
        bus_idle(1);

        // overflow on the second instance
        apb_write(32'h00, 32'h9);
        apb_write(32'h00, 32'h8);
        check("ovf_irq_lag", {31'h0, irq_ovf}, 32'h0);
        apb_read(32'h08, d, dv);
        check("ovf_wrap", dv, 32'h0);
        check("ovf_irq", {31'h0, irq_ovf}, 32'h1);
        apb_read(32'h04, d, dv);
        check("ovf_stat", dv, 32'h2);
        apb_write(32'h04, 32'h2);
        check("ovf_irq_hold", {31'h0, irq_ovf}, 32'h1);
        bus_idle(1);
        check("ovf_irq_clr", {31'h0, irq_ovf}, 32'h0);
        apb_read(32'h04, d, dv);
        check("ovf_stat_clr", dv, 32'h0);
        bus_idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
